// File: rtl/plab5_mcore_mem_arbiter_pkg.sv
// Shared definitions for the multicore memory arbiter: FSM state encoding and
// memory message field-width helpers (type | opaque | addr | len | data).
package plab5_mcore_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MREQ  = 2'd1,
        MRESP = 2'd2,
        PRESP = 2'd3
    } arb_state_e;

    localparam int MEM_TYPE_NBITS = 3;
    localparam int PERF_CNT_NBITS = 16;

    // len counts bytes in the data field; 0 encodes a full-width access
    function automatic int mem_len_nbits(input int data_nbits);
        return $clog2(data_nbits / 8);
    endfunction

    function automatic int mem_req_msg_nbits(input int o, input int a, input int d);
        return MEM_TYPE_NBITS + o + a + mem_len_nbits(d) + d;
    endfunction

    function automatic int mem_resp_msg_nbits(input int o, input int d);
        return MEM_TYPE_NBITS + o + mem_len_nbits(d) + d;
    endfunction

endpackage

// File: rtl/plab5_mcore_mem_arbiter_if.sv
// Bundles the per-core proc-side val/rdy ports and the single main-memory port
// seen by the arbiter; master is the arbiter's view, slave the environment's.
interface plab5_mcore_mem_arbiter_if #(
    parameter int nreqs           = 4,
    parameter int opaque_nbits    = 8,
    parameter int addr_nbits      = 32,
    parameter int proc_data_nbits = 32,
    parameter int mem_data_nbits  = 128
) ();
    import plab5_mcore_mem_arbiter_pkg::*;

    localparam int REQ_W   = mem_req_msg_nbits(opaque_nbits, addr_nbits, proc_data_nbits);
    localparam int RESP_W  = mem_resp_msg_nbits(opaque_nbits, proc_data_nbits);
    localparam int MREQ_W  = mem_req_msg_nbits(opaque_nbits, addr_nbits, mem_data_nbits);
    localparam int MRESP_W = mem_resp_msg_nbits(opaque_nbits, mem_data_nbits);

    logic [nreqs-1:0]       req_val;
    logic [nreqs-1:0]       req_rdy;
    logic [nreqs*REQ_W-1:0] req_msg;
    logic [nreqs-1:0]       resp_val;
    logic [nreqs-1:0]       resp_rdy;
    logic [RESP_W-1:0]      resp_msg;
    logic                   mem_req_val;
    logic                   mem_req_rdy;
    logic [MREQ_W-1:0]      mem_req_msg;
    logic                   mem_resp_val;
    logic                   mem_resp_rdy;
    logic [MRESP_W-1:0]     mem_resp_msg;

    modport master (
        input  req_val, req_msg, resp_rdy, mem_req_rdy, mem_resp_val, mem_resp_msg,
        output req_rdy, resp_val, resp_msg, mem_req_val, mem_req_msg, mem_resp_rdy
    );

    modport slave (
        output req_val, req_msg, resp_rdy, mem_req_rdy, mem_resp_val, mem_resp_msg,
        input  req_rdy, resp_val, resp_msg, mem_req_val, mem_req_msg, mem_resp_rdy
    );

endinterface

// File: rtl/plab5_mcore_mem_arbiter_rr_picker.sv
// Combinational round-robin winner: first set val bit scanning upward from ptr,
// wrapping modulo nreqs; reports the winner one-hot and as an index.
module plab5_mcore_rr_picker #(
    parameter  int nreqs = 4,
    localparam int PW    = $clog2(nreqs)
) (
    input  logic [nreqs-1:0] val,
    input  logic [PW-1:0]    ptr,
    output logic [nreqs-1:0] gnt_onehot,
    output logic [PW-1:0]    gnt_idx,
    output logic             gnt_any
);

    logic [PW-1:0] cand;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_any    = 1'b0;
        cand       = '0;
        for (int k = 0; k < nreqs; k++) begin
            cand = PW'((int'(ptr) + k) % nreqs);
            if (!gnt_any && val[cand]) begin
                gnt_any          = 1'b1;
                gnt_idx          = cand;
                gnt_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/plab5_mcore_mem_arbiter.sv
// Round-robin arbiter sharing one cache-line memory port among nreqs narrow
// requesters, one transaction in flight. Optional counters: PLAB5_MCORE_MEM_ARB_PERF_EN.
module plab5_mcore_mem_arbiter #(
    parameter int nreqs           = 4,
    parameter int opaque_nbits    = 8,
    parameter int addr_nbits      = 32,
    parameter int proc_data_nbits = 32,
    parameter int mem_data_nbits  = 128
) (
    input  logic                       clk,
    input  logic                       reset,
    plab5_mcore_mem_arbiter_if.master  bus
`ifdef PLAB5_MCORE_MEM_ARB_PERF_EN
    ,
    output logic [nreqs*16-1:0]        perf_grants,
    output logic [31:0]                perf_wait
`endif
);
    import plab5_mcore_mem_arbiter_pkg::*;

    localparam int TW      = MEM_TYPE_NBITS;
    localparam int OW      = opaque_nbits;
    localparam int AW      = addr_nbits;
    localparam int PD      = proc_data_nbits;
    localparam int MD      = mem_data_nbits;
    localparam int PLW     = mem_len_nbits(PD);
    localparam int MLW     = mem_len_nbits(MD);
    localparam int REQ_W   = mem_req_msg_nbits(OW, AW, PD);
    localparam int RESP_W  = mem_resp_msg_nbits(OW, PD);
    localparam int MREQ_W  = mem_req_msg_nbits(OW, AW, MD);
    localparam int PW      = $clog2(nreqs);

    arb_state_e         state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      gnt_q, gnt_d;
    logic [MREQ_W-1:0]  mem_req_msg_q, mem_req_msg_d;
    logic [RESP_W-1:0]  resp_msg_q, resp_msg_d;
    logic               mem_req_val_q, mem_req_val_d;
    logic               mem_resp_rdy_q, mem_resp_rdy_d;
    logic [nreqs-1:0]   resp_val_q, resp_val_d;

    logic [nreqs-1:0]   pick_onehot;
    logic [PW-1:0]      pick_idx;
    logic               pick_any;

    logic [REQ_W-1:0]   sel_req;
    logic [TW-1:0]      sel_type;
    logic [OW-1:0]      sel_opaque;
    logic [AW-1:0]      sel_addr;
    logic [PLW-1:0]     sel_len;
    logic [PD-1:0]      sel_data;
    logic [TW-1:0]      mr_type;
    logic [OW-1:0]      mr_opaque;
    logic [MLW-1:0]     mr_len;
    logic [MD-1:0]      mr_data;
    logic               unused_bits;

    plab5_mcore_rr_picker #(.nreqs(nreqs)) u_picker (
        .val        (bus.req_val),
        .ptr        (ptr_q),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .gnt_any    (pick_any)
    );

    assign sel_req = bus.req_msg[int'(pick_idx)*REQ_W +: REQ_W];
    assign {sel_type, sel_opaque, sel_addr, sel_len, sel_data} = sel_req;
    assign {mr_type, mr_opaque, mr_len, mr_data} = bus.mem_resp_msg;
    assign unused_bits = ^{mr_len, mr_data};

    // Reads carry no payload, so their data field is forced to zero
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gnt_d         = gnt_q;
        mem_req_msg_d = mem_req_msg_q;
        resp_msg_d    = resp_msg_q;
        case (state_q)
            IDLE: if (pick_any) begin
                state_d       = MREQ;
                gnt_d         = pick_idx;
                mem_req_msg_d = {sel_type, sel_opaque, sel_addr, MLW'(sel_len),
                                 (sel_type == '0) ? MD'(0) : MD'(sel_data)};
            end
            MREQ: if (bus.mem_req_rdy) state_d = MRESP;
            MRESP: if (bus.mem_resp_val) begin
                state_d    = PRESP;
                resp_msg_d = {mr_type, mr_opaque, PLW'(0), mr_data[PD-1:0]};
            end
            PRESP: if (bus.resp_rdy[gnt_q]) begin
                state_d = IDLE;
                ptr_d   = (gnt_q == PW'(nreqs - 1)) ? '0 : gnt_q + PW'(1);
            end
            default: state_d = IDLE;
        endcase
        mem_req_val_d  = (state_d == MREQ);
        mem_resp_rdy_d = (state_d == MRESP);
        resp_val_d     = (state_d == PRESP) ? (nreqs'(1) << gnt_d) : '0;
    end

`ifdef PLAB5_MCORE_MEM_ARB_PERF_EN
    logic [nreqs*16-1:0] perf_grants_q, perf_grants_d;
    logic [31:0]         perf_wait_q, perf_wait_d;

    always_comb begin
        perf_grants_d = perf_grants_q;
        perf_wait_d   = perf_wait_q;
        if (state_q == IDLE && pick_any &&
            perf_grants_q[int'(pick_idx)*PERF_CNT_NBITS +: PERF_CNT_NBITS] != '1)
            perf_grants_d[int'(pick_idx)*PERF_CNT_NBITS +: PERF_CNT_NBITS] =
                perf_grants_q[int'(pick_idx)*PERF_CNT_NBITS +: PERF_CNT_NBITS] + 16'd1;
        if (state_q != IDLE && (|bus.req_val) && perf_wait_q != '1)
            perf_wait_d = perf_wait_q + 32'd1;
    end

    assign perf_grants = perf_grants_q;
    assign perf_wait   = perf_wait_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            gnt_q          <= '0;
            mem_req_msg_q  <= '0;
            resp_msg_q     <= '0;
            mem_req_val_q  <= 1'b0;
            mem_resp_rdy_q <= 1'b0;
            resp_val_q     <= '0;
`ifdef PLAB5_MCORE_MEM_ARB_PERF_EN
            perf_grants_q  <= '0;
            perf_wait_q    <= '0;
`endif
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            gnt_q          <= gnt_d;
            mem_req_msg_q  <= mem_req_msg_d;
            resp_msg_q     <= resp_msg_d;
            mem_req_val_q  <= mem_req_val_d;
            mem_resp_rdy_q <= mem_resp_rdy_d;
            resp_val_q     <= resp_val_d;
`ifdef PLAB5_MCORE_MEM_ARB_PERF_EN
            perf_grants_q  <= perf_grants_d;
            perf_wait_q    <= perf_wait_d;
`endif
        end
    end

    assign bus.req_rdy      = (state_q == IDLE) ? pick_onehot : '0;
    assign bus.mem_req_val  = mem_req_val_q;
    assign bus.mem_req_msg  = mem_req_msg_q;
    assign bus.mem_resp_rdy = mem_resp_rdy_q;
    assign bus.resp_val     = resp_val_q;
    assign bus.resp_msg     = resp_msg_q;

endmodule

// File: tb/tb_plab5_mcore_mem_arbiter.sv
// Directed bench for the round-robin memory arbiter: reset state, read/write
// translation, contention order, backpressure and reset mid-transaction.
module tb_plab5_mcore_mem_arbiter;

    localparam int NREQS   = 4;
    localparam int REQ_W   = 77;
    localparam int RESP_W  = 45;
    localparam int MREQ_W  = 175;
    localparam int MRESP_W = 143;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

`ifdef PLAB5_MCORE_MEM_ARB_PERF_EN
    logic [NREQS*16-1:0] perf_grants;
    logic [31:0]         perf_wait;
`endif

    plab5_mcore_mem_arbiter_if #(
        .nreqs(NREQS), .opaque_nbits(8), .addr_nbits(32),
        .proc_data_nbits(32), .mem_data_nbits(128)
    ) bus ();

    plab5_mcore_mem_arbiter #(
        .nreqs(NREQS), .opaque_nbits(8), .addr_nbits(32),
        .proc_data_nbits(32), .mem_data_nbits(128)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.master)
`ifdef PLAB5_MCORE_MEM_ARB_PERF_EN
        ,
        .perf_grants (perf_grants),
        .perf_wait   (perf_wait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // One full transaction; resp_val must appear on the third edge after the
    // request fires when the memory side never stalls.
    task automatic applyStimulus(input string tag, input logic [3:0] val_mask,
                                 input logic [3:0] after_mask, input int exp_gnt,
                                 input logic [MREQ_W-1:0] exp_mem,
                                 input logic [MRESP_W-1:0] mem_resp,
                                 input logic [RESP_W-1:0] exp_resp,
                                 input int req_wait, input int resp_wait);
        logic [3:0] gnt_hot;
        gnt_hot = 4'b0001 << exp_gnt;
        bus.req_val = val_mask;
        #1;
        checkOutput({tag, "_req_rdy"}, 256'(bus.req_rdy), 256'(gnt_hot));
        tick();
        bus.req_val = after_mask;
        #1;
        for (int i = 0; i < req_wait; i++) begin
            checkOutput({tag, "_mreq_hold"}, 256'(bus.mem_req_msg), 256'(exp_mem));
            checkOutput({tag, "_rdy_quiet"}, 256'(bus.req_rdy), 256'(0));
            tick();
        end
        checkOutput({tag, "_mreq_val"}, 256'(bus.mem_req_val), 256'(1));
        checkOutput({tag, "_mreq_msg"}, 256'(bus.mem_req_msg), 256'(exp_mem));
        bus.mem_req_rdy = 1'b1;
        tick();
        bus.mem_req_rdy = 1'b0;
        #1;
        checkOutput({tag, "_mresp_rdy"}, 256'(bus.mem_resp_rdy), 256'(1));
        checkOutput({tag, "_mreq_drop"}, 256'(bus.mem_req_val), 256'(0));
        bus.mem_resp_val = 1'b1;
        bus.mem_resp_msg = mem_resp;
        tick();
        bus.mem_resp_val = 1'b0;
        bus.mem_resp_msg = '0;
        bus.resp_rdy     = ~gnt_hot;
        #1;
        for (int i = 0; i < resp_wait; i++) begin
            checkOutput({tag, "_resp_hold"}, 256'(bus.resp_msg), 256'(exp_resp));
            checkOutput({tag, "_rdy_quiet2"}, 256'(bus.req_rdy), 256'(0));
            tick();
        end
        checkOutput({tag, "_resp_val"}, 256'(bus.resp_val), 256'(gnt_hot));
        checkOutput({tag, "_resp_msg"}, 256'(bus.resp_msg), 256'(exp_resp));
        checkOutput({tag, "_mresp_off"}, 256'(bus.mem_resp_rdy), 256'(0));
        bus.resp_rdy = gnt_hot;
        tick();
        bus.resp_rdy = '0;
        #1;
        checkOutput({tag, "_resp_done"}, 256'(bus.resp_val), 256'(0));
    endtask

    initial begin
        logic [REQ_W-1:0] slot [NREQS];
        logic [7:0]       opq;
        logic [31:0]      addr;
        logic [31:0]      wdata;
        int               g;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.req_val      = '0;
        bus.req_msg      = '0;
        bus.resp_rdy     = '0;
        bus.mem_req_rdy  = 1'b0;
        bus.mem_resp_val = 1'b0;
        bus.mem_resp_msg = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        checkOutput("rst_req_rdy",   256'(bus.req_rdy),      256'(0));
        checkOutput("rst_resp_val",  256'(bus.resp_val),     256'(0));
        checkOutput("rst_mreq_val",  256'(bus.mem_req_val),  256'(0));
        checkOutput("rst_mresp_rdy", 256'(bus.mem_resp_rdy), 256'(0));
        checkOutput("rst_mreq_msg",  256'(bus.mem_req_msg),  256'(0));
        checkOutput("rst_resp_msg",  256'(bus.resp_msg),     256'(0));

        // Contention: all four hold val; rotation must be 0,1,2,3,0
        for (int i = 0; i < NREQS; i++) begin
            opq   = 8'hA0 + 8'(i);
            addr  = 32'h4000 + 32'(16 * i);
            wdata = 32'h1111_1111 * 32'(i + 1);
            slot[i] = {3'd1, opq, addr, 2'd0, wdata};
        end
        bus.req_msg = {slot[3], slot[2], slot[1], slot[0]};
        for (int k = 0; k < 5; k++) begin
            g     = k % NREQS;
            opq   = 8'hA0 + 8'(g);
            addr  = 32'h4000 + 32'(16 * g);
            wdata = 32'h1111_1111 * 32'(g + 1);
            applyStimulus($sformatf("rr%0d", k), 4'b1111, 4'b1111, g,
                          {3'd1, opq, addr, 4'd0, 96'd0, wdata},
                          {3'd1, opq, 4'd0, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h5000 + 32'(g)},
                          {3'd1, opq, 2'd0, 32'h5000 + 32'(g)}, 0, 0);
        end
`ifdef PLAB5_MCORE_MEM_ARB_PERF_EN
        checkOutput("perf_grants", 256'(perf_grants), 256'({16'd1, 16'd1, 16'd1, 16'd2}));
        checkOutput("perf_wait_nz", 256'(perf_wait != 32'd0), 256'(1));
`endif
        bus.req_val = '0;

        // Single read from requester 1: stray write data must not leak through
        bus.req_msg = '0;
        bus.req_msg[1*REQ_W +: REQ_W] = {3'd0, 8'h11, 32'h1000, 2'd0, 32'hFFFF_FFFF};
        applyStimulus("read", 4'b0010, 4'b0000, 1,
                      {3'd0, 8'h11, 32'h1000, 4'd0, 128'd0},
                      {3'd0, 8'h11, 4'd0, 128'h0123456789ABCDEF01234567DEADBEEF},
                      {3'd0, 8'h11, 2'd0, 32'hDEADBEEF}, 0, 0);

        // Write from requester 2 with backpressure; others hold val meanwhile
        bus.req_msg = '0;
        bus.req_msg[2*REQ_W +: REQ_W] = {3'd1, 8'h22, 32'h2000, 2'd3, 32'hCAFEF00D};
        applyStimulus("write", 4'b0100, 4'b1011, 2,
                      {3'd1, 8'h22, 32'h2000, 4'd3, 96'd0, 32'hCAFEF00D},
                      {3'd1, 8'h22, 4'd5, {128{1'b1}}},
                      {3'd1, 8'h22, 2'd0, 32'hFFFF_FFFF}, 5, 3);

        // Stray memory response in IDLE
        bus.req_val      = '0;
        bus.mem_resp_val = 1'b1;
        bus.mem_resp_msg = {3'd0, 8'h77, 4'd0, 128'h1234};
        #1;
        checkOutput("stray_mresp_rdy", 256'(bus.mem_resp_rdy), 256'(0));
        tick();
        tick();
        checkOutput("stray_resp_val", 256'(bus.resp_val),    256'(0));
        checkOutput("stray_mreq_val", 256'(bus.mem_req_val), 256'(0));
        bus.mem_resp_val = 1'b0;
        bus.mem_resp_msg = '0;

        // Requester 1 again (ptr=3 wraps to 1), leaving ptr=2
        bus.req_msg = '0;
        bus.req_msg[1*REQ_W +: REQ_W] = {3'd0, 8'h33, 32'h3000, 2'd1, 32'h0};
        bus.req_msg[3*REQ_W +: REQ_W] = {3'd0, 8'h44, 32'h3100, 2'd0, 32'h0};
        applyStimulus("wrap", 4'b0010, 4'b0000, 1,
                      {3'd0, 8'h33, 32'h3000, 4'd1, 128'd0},
                      {3'd0, 8'h33, 4'd0, 128'hABCD_0000_0000_0000_0000_0000_8765_4321},
                      {3'd0, 8'h33, 2'd0, 32'h8765_4321}, 0, 0);

        // Requester 3 wins from ptr=2, then reset lands while in MRESP
        bus.req_val = 4'b1000;
        #1;
        checkOutput("mid_req_rdy", 256'(bus.req_rdy), 256'(4'b1000));
        tick();
        bus.req_val     = '0;
        bus.mem_req_rdy = 1'b1;
        tick();
        bus.mem_req_rdy = 1'b0;
        #1;
        checkOutput("mid_mresp_rdy", 256'(bus.mem_resp_rdy), 256'(1));
        reset            = 1'b1;
        bus.mem_resp_val = 1'b1;
        bus.mem_resp_msg = {3'd0, 8'h44, 4'd0, 128'h55};
        tick();
        reset            = 1'b0;
        bus.mem_resp_val = 1'b0;
        bus.mem_resp_msg = '0;
        #1;
        checkOutput("mid_rst_resp_val",  256'(bus.resp_val),     256'(0));
        checkOutput("mid_rst_mreq_val",  256'(bus.mem_req_val),  256'(0));
        checkOutput("mid_rst_mresp_rdy", 256'(bus.mem_resp_rdy), 256'(0));
        checkOutput("mid_rst_mreq_msg",  256'(bus.mem_req_msg),  256'(0));
        tick();
        checkOutput("mid_rst_no_resp", 256'(bus.resp_val), 256'(0));
        bus.req_val = 4'b1111;
        #1;
        checkOutput("mid_rst_ptr0", 256'(bus.req_rdy), 256'(4'b0001));
        bus.req_val = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
